// File: rtl/spi_slave_responder.sv
// SPI slave: oversampled SCLK/SS_N/MOSI, 8-bit MSB-first frames, FWFT RX FIFO, one-entry TX holding register.
// Optional SPI_SLV_ECHO_EN: an empty TX slot is refilled with the last received byte instead of UNDERRUN_BYTE.
module spi_slave_responder #(
    parameter int unsigned RX_DEPTH      = 4,
    parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic       sclk_i,
    input  logic       ss_ni,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       overrun_o,
    output logic       underrun_o,
    output logic       frame_err_o
);
    localparam int unsigned AW = $clog2(RX_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state_q;
    logic [1:0]  sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic        sclk_prev_q, ss_prev_q;
    logic        cpol_q, cpha_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  tx_sr_q, hold_q;
    logic [6:0]  rx_sr_q;
    logic        hold_full_q, oe_q, overrun_q, underrun_q, frame_err_q;
    logic [AW:0] wptr_q, rptr_q;
    logic [7:0]  mem_q [RX_DEPTH];
`ifdef SPI_SLV_ECHO_EN
    logic [7:0]  last_rx_q;
`endif

    logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic       lead_ev, trail_ev, sample_ev, shift_ev;
    logic       active, byte_done, load, fifo_full, fifo_empty, pop, push;
    logic [7:0] rx_byte, fill_byte, load_byte;

    // Two-flop synchronisers plus a third flop for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= 2'b11;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk_i};
            ss_sync_q   <= {ss_sync_q[0], ss_ni};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            sclk_prev_q <= sclk_sync_q[1];
            ss_prev_q   <= ss_sync_q[1];
        end
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
    assign ss_fall   = ~ss_sync_q[1] & ss_prev_q;
    assign ss_rise   = ss_sync_q[1] & ~ss_prev_q;
    assign lead_ev   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_ev  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_ev = cpha_q ? trail_ev : lead_ev;
    assign shift_ev  = cpha_q ? lead_ev : trail_ev;

    assign active     = (state_q == ACTIVE);
    assign byte_done  = active & ~ss_rise & sample_ev & (bit_cnt_q == 3'd7);
    assign load       = (~active & ss_fall) | byte_done;
    assign rx_byte    = {rx_sr_q, mosi_sync_q[1]};
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop        = ~fifo_empty & rx_ready_i;
    assign push       = byte_done & (~fifo_full | pop);

`ifdef SPI_SLV_ECHO_EN
    assign fill_byte = byte_done ? rx_byte : last_rx_q;
`else
    assign fill_byte = UNDERRUN_BYTE;
`endif
    assign load_byte = hold_full_q ? hold_q : fill_byte;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt_q   <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            oe_q        <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SPI_SLV_ECHO_EN
            last_rx_q   <= '0;
`endif
        end else begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SPI_SLV_ECHO_EN
            underrun_q  <= 1'b0;
`else
            underrun_q  <= load & ~hold_full_q;
`endif
            // Write and consume are exclusive: a write needs the slot empty, a consume needs it full.
            if (tx_valid_i && !hold_full_q) begin
                hold_q      <= tx_data_i;
                hold_full_q <= 1'b1;
            end else if (load && hold_full_q) begin
                hold_full_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_q   <= ACTIVE;
                        cpol_q    <= cpol_i;
                        cpha_q    <= cpha_i;
                        tx_sr_q   <= load_byte;
                        bit_cnt_q <= '0;
                        oe_q      <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state_q     <= IDLE;
                        oe_q        <= 1'b0;
                        frame_err_q <= (bit_cnt_q != 3'd0);
                        bit_cnt_q   <= '0;
                    end else if (sample_ev) begin
                        rx_sr_q   <= rx_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (byte_done) begin
                            tx_sr_q   <= load_byte;
                            overrun_q <= ~push;
`ifdef SPI_SLV_ECHO_EN
                            last_rx_q <= rx_byte;
`endif
                        end
                    end else if (shift_ev && bit_cnt_q != 3'd0) begin
                        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= rx_byte;
    end

    assign miso_o      = active & tx_sr_q[7];
    assign miso_oe_o   = oe_q;
    assign tx_ready_o  = ~hold_full_q;
    assign rx_valid_o  = ~fifo_empty;
    assign rx_data_o   = fifo_empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
    assign overrun_o   = overrun_q;
    assign underrun_o  = underrun_q;
    assign frame_err_o = frame_err_q;
endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: bit-banged SPI master, scoreboard queues for MISO and RX bytes.
// Honours SPI_SLV_ECHO_EN when computing the byte expected on MISO for an empty TX slot.
module tb_spi_slave_responder;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, rx_ready = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, overrun, underrun, frame_err;
    logic [7:0] rx_data;

    spi_slave_responder #(.RX_DEPTH(4), .UNDERRUN_BYTE(8'hFF)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cpol_i(cpol), .cpha_i(cpha), .sclk_i(sclk),
        .ss_ni(ss_n), .mosi_i(mosi), .miso_o(miso), .miso_oe_o(miso_oe),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .overrun_o(overrun), .underrun_o(underrun), .frame_err_o(frame_err)
    );

    always #5 clk = ~clk;

`ifdef SPI_SLV_ECHO_EN
    localparam int UN = 0;
`else
    localparam int UN = 1;
`endif

    int checks = 0, errors = 0;
    int ov_cnt = 0, un_cnt = 0, fe_cnt = 0;
    logic [7:0] rx_q[$], mi_q[$];
    logic [7:0] last_rx_m = 8'h00;

    always @(posedge clk) begin
        if (overrun)   ov_cnt <= ov_cnt + 1;
        if (underrun)  un_cnt <= un_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fill();
`ifdef SPI_SLV_ECHO_EN
        return last_rx_m;
`else
        return 8'hFF;
`endif
    endfunction

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi = mo[i]; half(); mi[i] = miso; sclk = ~cpol; half(); sclk = cpol;
            end else begin
                sclk = ~cpol; mosi = mo[i]; half(); mi[i] = miso; sclk = cpol; half();
            end
        end
    endtask

    task automatic xfer(input logic [7:0] mo, input logic keep);
        logic [7:0] mi, exp;
        bits(mo, 8, mi);
        exp = (mi_q.size() > 0) ? mi_q.pop_front() : 8'hxx;
        chk("miso_byte", mi, exp);
        if (keep) rx_q.push_back(mo);
        last_rx_m = mo;
    endtask

    task automatic frame_begin(input logic p, input logic h);
        cpol = p; cpha = h; sclk = p;
        half(); ss_n = 1'b0; half();
    endtask

    task automatic frame_end();
        half(); ss_n = 1'b1; half();
    endtask

    task automatic tx_write(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 50) begin @(negedge clk); n++; end
        chk("tx_ready_wait", tx_ready, 1);
        tx_data = b; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic drain();
        logic [7:0] exp;
        while (rx_q.size() > 0) begin
            int n = 0;
            while (!rx_valid && n < 50) begin @(negedge clk); n++; end
            chk("rx_valid", rx_valid, 1);
            exp = rx_q.pop_front();
            chk("rx_data", rx_data, exp);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        chk("rx_empty", rx_valid, 0);
    endtask

    initial begin
        int un0, ov0, fe0;
        logic [7:0] mi_d;
        logic [7:0] ov_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        repeat (4) @(negedge clk);
        chk("reset_ctrl", {miso, miso_oe, tx_ready, rx_valid}, 4'b0010);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_pulses", {overrun, underrun, frame_err}, 3'b000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0, held byte answers the first byte
        tx_write(8'h3C);
        un0 = un_cnt;
        frame_begin(1'b0, 1'b0);
        chk("m0_oe", miso_oe, 1);
        chk("m0_tx_ready_after_load", tx_ready, 1);
        mi_q.push_back(8'h3C);
        xfer(8'hA5, 1'b1);
        frame_end();
        chk("m0_oe_off", miso_oe, 0);
        chk("m0_miso_off", miso, 0);
        chk("m0_underrun", un_cnt - un0, UN);
        drain();

        // Mode 3, back-to-back bytes, second TX byte written while the first shifts
        tx_write(8'hC3);
        un0 = un_cnt;
        frame_begin(1'b1, 1'b1);
        tx_write(8'h5A);
        mi_q.push_back(8'hC3);
        xfer(8'h12, 1'b1);
        mi_q.push_back(8'h5A);
        xfer(8'h34, 1'b1);
        frame_end();
        chk("m3_underrun", un_cnt - un0, UN);
        drain();

        // Modes 1 and 2 with no TX byte held
        for (int m = 1; m <= 2; m++) begin
            un0 = un_cnt;
            mi_q.push_back(fill());
            frame_begin(m == 2, m == 1);
            chk("m12_underrun_at_load", un_cnt - un0, UN);
            xfer(8'h81, 1'b1);
            frame_end();
            // the byte-end reload also finds the slot empty
            chk("m12_underrun_total", un_cnt - un0, 2 * UN);
            drain();
        end

        // Overrun: five bytes into a four-deep FIFO
        ov0 = ov_cnt;
        rx_ready = 1'b0;
        frame_begin(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            mi_q.push_back(fill());
            xfer(ov_bytes[k], k < 4);
        end
        frame_end();
        chk("overrun_pulses", ov_cnt - ov0, 1);
        drain();

        // Frame error after three bits, then a clean frame
        fe0 = fe_cnt;
        frame_begin(1'b0, 1'b0);
        bits(8'hC7, 3, mi_d);
        frame_end();
        chk("frame_err_pulse", fe_cnt - fe0, 1);
        chk("frame_err_fifo", rx_valid, 0);
        chk("frame_err_oe", miso_oe, 0);
        mi_q.push_back(fill());
        frame_begin(1'b0, 1'b0);
        xfer(8'h96, 1'b1);
        frame_end();
        drain();

        // Reset mid-frame with a byte held
        frame_begin(1'b0, 1'b0);
        tx_write(8'hE1);
        chk("held_ready_low", tx_ready, 0);
        bits(8'hF0, 5, mi_d);
        rst_n = 1'b0; ss_n = 1'b1; sclk = 1'b0; cpol = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset_ctrl", {miso, miso_oe, tx_ready, rx_valid}, 4'b0010);
        chk("midreset_rest", {rx_data, overrun, underrun, frame_err}, 11'h000);
        last_rx_m = 8'h00;
        rst_n = 1'b1;
        half();
        mi_q.push_back(fill());
        frame_begin(1'b0, 1'b0);
        xfer(8'h5A, 1'b1);
        frame_end();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
